// File: rtl/cpu_defs.sv
// Shared fetch-stage definitions: NOP encoding, fetch exception codes,
// fetch FSM states and the IF/ID update operations.
package cpu_defs;

    localparam logic [31:0] NOP                    = 32'h0000_0013;
    localparam logic [3:0]  EXC_INSTR_MISALIGNED   = 4'd0;
    localparam logic [3:0]  EXC_INSTR_ACCESS_FAULT = 4'd1;

    typedef enum logic {
        ST_RUN           = 1'b0,
        ST_WAIT_REDIRECT = 1'b1
    } fetch_state_e;

    typedef enum logic [1:0] {
        IFID_HOLD   = 2'd0,
        IFID_BUBBLE = 2'd1,
        IFID_LOAD   = 2'd2
    } ifid_op_e;

    typedef struct packed {
        logic        en;
        logic [3:0]  code;
        logic [63:0] val;
    } fetch_exc_t;

endpackage

// File: rtl/fetch_if_id_reg.sv
// IF/ID pipeline register: hold, insert a bubble, or load a new fetch slot.
module fetch_if_id_reg
    import cpu_defs::*;
(
    input  logic        clk,
    input  logic        rst,
    input  ifid_op_e    op,
    input  logic        ld_valid,
    input  logic [63:0] ld_pc,
    input  logic [31:0] ld_instr,
    input  fetch_exc_t  ld_exc,
    output logic        id_valid,
    output logic [63:0] id_pc,
    output logic [31:0] id_instr,
    output fetch_exc_t  id_exc
);

    logic        valid_q, valid_d;
    logic [63:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    fetch_exc_t  exc_q, exc_d;

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path leaves a value unassigned and no latch is inferred.
        valid_d = valid_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        exc_d   = exc_q;
        case (op)
            IFID_BUBBLE: begin
                valid_d  = 1'b0;
                instr_d  = NOP;
                exc_d.en = 1'b0;
            end
            IFID_LOAD: begin
                valid_d = ld_valid;
                pc_d    = ld_pc;
                instr_d = ld_instr;
                exc_d   = ld_exc;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values regardless of statement order.
        if (rst) begin
            valid_q <= 1'b0;
            pc_q    <= '0;
            instr_q <= NOP;
            exc_q   <= '0;
        end else begin
            valid_q <= valid_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            exc_q   <= exc_d;
        end
    end

    assign id_valid = valid_q;
    assign id_pc    = pc_q;
    assign id_instr = instr_q;
    assign id_exc   = exc_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC register, redirect/exception FSM and IF/ID slot.
// Optional FETCH_MISALIGN_CHECK_EN raises a misaligned-fetch exception on PC[1:0]!=0.
module fetch_unit
    import cpu_defs::*;
#(
    parameter logic [63:0] RESET_PC = 64'h0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        flush,
    input  logic        redirect_en,
    input  logic [63:0] redirect_pc,
    output logic [63:0] pc_addr,
    input  logic [31:0] instruction,
    input  logic        imem_exc_en,
    input  logic [3:0]  imem_exc_code,
    input  logic [63:0] imem_exc_val,
    output logic        id_valid,
    output logic [63:0] id_pc,
    output logic [31:0] id_instr,
    output logic        id_exc_en,
    output logic [3:0]  id_exc_code,
    output logic [63:0] id_exc_val
);

    logic [63:0]  pc_q, pc_d;
    fetch_state_e state_q, state_d;
    fetch_exc_t   fetch_exc;
    ifid_op_e     ifid_op;
    logic [31:0]  ld_instr;
    fetch_exc_t   ld_exc;
    fetch_exc_t   id_exc;

    always_comb begin
        fetch_exc = '{en: imem_exc_en, code: imem_exc_code, val: imem_exc_val};
`ifdef FETCH_MISALIGN_CHECK_EN
        if (pc_q[1:0] != 2'b00)
            fetch_exc = '{en: 1'b1, code: EXC_INSTR_MISALIGNED, val: pc_q};
`endif
    end

    always_comb begin
        pc_d     = pc_q;
        state_d  = state_q;
        ifid_op  = IFID_HOLD;
        ld_instr = instruction;
        ld_exc   = '0;
        if (redirect_en) begin
            pc_d    = redirect_pc;
            state_d = ST_RUN;
            ifid_op = IFID_BUBBLE;
        end else if (flush) begin
            ifid_op = IFID_BUBBLE;
        end else if (stall) begin
            ifid_op = IFID_HOLD;
        end else if (state_q == ST_RUN) begin
            ifid_op = IFID_LOAD;
            if (fetch_exc.en) begin
                // The faulting PC stays put until software redirects away from it.
                ld_instr = NOP;
                ld_exc   = fetch_exc;
                state_d  = ST_WAIT_REDIRECT;
            end else begin
                pc_d = pc_q + 64'd4;
            end
        end else begin
            ifid_op = IFID_BUBBLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q    <= RESET_PC;
            state_q <= ST_RUN;
        end else begin
            pc_q    <= pc_d;
            state_q <= state_d;
        end
    end

    fetch_if_id_reg u_if_id (
        .clk      (clk),
        .rst      (rst),
        .op       (ifid_op),
        .ld_valid (1'b1),
        .ld_pc    (pc_q),
        .ld_instr (ld_instr),
        .ld_exc   (ld_exc),
        .id_valid (id_valid),
        .id_pc    (id_pc),
        .id_instr (id_instr),
        .id_exc   (id_exc)
    );

    assign pc_addr     = pc_q;
    assign id_exc_en   = id_exc.en;
    assign id_exc_code = id_exc.code;
    assign id_exc_val  = id_exc.val;

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: directed steps push expected post-edge
// state into a queue; a monitor pops and compares after every clock edge.
module tb_fetch_unit;

    typedef struct {
        logic [63:0] pc_addr;
        logic        valid;
        logic        exc_en;
        bit          chk_idpc;
        logic [63:0] id_pc;
        bit          chk_instr;
        logic [31:0] instr;
        bit          chk_detail;
        logic [3:0]  code;
        logic [63:0] val;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic        redirect_en = 1'b0;
    logic [63:0] redirect_pc = '0;
    logic [63:0] pc_addr;
    logic [31:0] instruction;
    logic        imem_exc_en = 1'b0;
    logic [3:0]  imem_exc_code = '0;
    logic [63:0] imem_exc_val = '0;
    logic        id_valid;
    logic [63:0] id_pc;
    logic [31:0] id_instr;
    logic        id_exc_en;
    logic [3:0]  id_exc_code;
    logic [63:0] id_exc_val;

    int   checks = 0;
    int   errors = 0;
    bit   stim_done = 1'b0;
    exp_t sb_q[$];

    always #5 clk = ~clk;

    // Instruction memory model: tag word carrying the low 16 address bits.
    assign instruction = {16'hC0DE, pc_addr[15:0]};

    fetch_unit #(.RESET_PC(64'h0)) dut (
        .clk           (clk),
        .rst           (rst),
        .stall         (stall),
        .flush         (flush),
        .redirect_en   (redirect_en),
        .redirect_pc   (redirect_pc),
        .pc_addr       (pc_addr),
        .instruction   (instruction),
        .imem_exc_en   (imem_exc_en),
        .imem_exc_code (imem_exc_code),
        .imem_exc_val  (imem_exc_val),
        .id_valid      (id_valid),
        .id_pc         (id_pc),
        .id_instr      (id_instr),
        .id_exc_en     (id_exc_en),
        .id_exc_code   (id_exc_code),
        .id_exc_val    (id_exc_val)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    function automatic exp_t e_full(input logic [63:0] pc, input logic v, input logic [63:0] ipc,
                                    input logic [31:0] ins, input logic xe, input logic [3:0] xc,
                                    input logic [63:0] xv);
        exp_t e;
        e.pc_addr = pc;  e.valid = v;  e.exc_en = xe;
        e.chk_idpc = 1'b1;  e.id_pc = ipc;
        e.chk_instr = 1'b1; e.instr = ins;
        e.chk_detail = 1'b1; e.code = xc; e.val = xv;
        return e;
    endfunction

    function automatic exp_t e_run(input logic [63:0] pc, input logic [63:0] ipc, input logic [31:0] ins);
        return e_full(pc, 1'b1, ipc, ins, 1'b0, 4'd0, 64'd0);
    endfunction

    // Bubble: only valid, exception flag, NOP and PC are defined.
    function automatic exp_t e_bub(input logic [63:0] pc, input bit with_nop);
        exp_t e;
        e = e_full(pc, 1'b0, 64'd0, 32'h0000_0013, 1'b0, 4'd0, 64'd0);
        e.chk_idpc = 1'b0;
        e.chk_detail = 1'b0;
        e.chk_instr = with_nop;
        return e;
    endfunction

    task automatic step(input logic r, input logic st, input logic fl, input logic re,
                        input logic [63:0] rpc, input logic xe, input logic [3:0] xc,
                        input logic [63:0] xv, input exp_t e);
        @(negedge clk);
        rst = r; stall = st; flush = fl; redirect_en = re; redirect_pc = rpc;
        imem_exc_en = xe; imem_exc_code = xc; imem_exc_val = xv;
        sb_q.push_back(e);
        @(posedge clk);
    endtask

    // Monitor: the slot is presented every edge; compare after the edge settles.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                check("pc_addr", pc_addr, e.pc_addr);
                check("id_valid", {63'd0, id_valid}, {63'd0, e.valid});
                check("id_exc_en", {63'd0, id_exc_en}, {63'd0, e.exc_en});
                if (e.chk_idpc)  check("id_pc", id_pc, e.id_pc);
                if (e.chk_instr) check("id_instr", {32'd0, id_instr}, {32'd0, e.instr});
                if (e.chk_detail) begin
                    check("id_exc_code", {60'd0, id_exc_code}, {60'd0, e.code});
                    check("id_exc_val", id_exc_val, e.val);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    localparam logic [31:0] NOP_W = 32'h0000_0013;

    initial begin
        // Reset state
        step(1,0,0,0, 64'h0, 0,4'd0,64'h0, e_full(64'h0, 0, 64'h0, NOP_W, 0, 4'd0, 64'h0));
        // Sequential fetch
        step(0,0,0,0, 64'h0, 0,4'd0,64'h0, e_run(64'h4, 64'h0, 32'hC0DE0000));
        step(0,0,0,0, 64'h0, 0,4'd0,64'h0, e_run(64'h8, 64'h4, 32'hC0DE0004));
        // Stall two edges at PC=8
        step(0,1,0,0, 64'h0, 0,4'd0,64'h0, e_run(64'h8, 64'h4, 32'hC0DE0004));
        step(0,1,0,0, 64'h0, 0,4'd0,64'h0, e_run(64'h8, 64'h4, 32'hC0DE0004));
        step(0,0,0,0, 64'h0, 0,4'd0,64'h0, e_run(64'hC, 64'h8, 32'hC0DE0008));
        // Redirect wins over stall
        step(0,1,0,1, 64'h100, 0,4'd0,64'h0, e_bub(64'h100, 1));
        step(0,0,0,0, 64'h0, 0,4'd0,64'h0, e_run(64'h104, 64'h100, 32'hC0DE0100));
        // Flush holds PC and bubbles, also over stall
        step(0,0,1,0, 64'h0, 0,4'd0,64'h0, e_bub(64'h104, 1));
        step(0,1,1,0, 64'h0, 0,4'd0,64'h0, e_bub(64'h104, 1));
        step(0,0,0,0, 64'h0, 0,4'd0,64'h0, e_run(64'h108, 64'h104, 32'hC0DE0104));
        // Access fault, wait for redirect, resume
        step(0,0,0,1, 64'h2000, 0,4'd0,64'h0, e_bub(64'h2000, 1));
        step(0,0,0,0, 64'h0, 1,4'd1,64'h2000, e_full(64'h2000, 1, 64'h2000, NOP_W, 1, 4'd1, 64'h2000));
        step(0,0,0,0, 64'h0, 1,4'd1,64'h2000, e_bub(64'h2000, 0));
        step(0,0,0,0, 64'h0, 0,4'd0,64'h0, e_bub(64'h2000, 0));
        step(0,1,0,0, 64'h0, 0,4'd0,64'h0, e_bub(64'h2000, 0));
        step(0,0,0,1, 64'h40, 0,4'd0,64'h0, e_bub(64'h40, 1));
        step(0,0,0,0, 64'h0, 0,4'd0,64'h0, e_run(64'h44, 64'h40, 32'hC0DE0040));
        // PC+4 wraps without an exception
        step(0,0,0,1, 64'hFFFF_FFFF_FFFF_FFFC, 0,4'd0,64'h0, e_bub(64'hFFFF_FFFF_FFFF_FFFC, 1));
        step(0,0,0,0, 64'h0, 0,4'd0,64'h0, e_run(64'h0, 64'hFFFF_FFFF_FFFF_FFFC, 32'hC0DEFFFC));
        // Misaligned redirect target
        step(0,0,0,1, 64'h102, 0,4'd0,64'h0, e_bub(64'h102, 1));
`ifdef FETCH_MISALIGN_CHECK_EN
        step(0,0,0,0, 64'h0, 1,4'd1,64'h555, e_full(64'h102, 1, 64'h102, NOP_W, 1, 4'd0, 64'h102));
`else
        step(0,0,0,0, 64'h0, 0,4'd0,64'h0, e_run(64'h106, 64'h102, 32'hC0DE0102));
`endif
        // Reach WAIT_REDIRECT, then reset while stalled with a fault pending
        step(0,0,0,1, 64'h300, 0,4'd0,64'h0, e_bub(64'h300, 1));
        step(0,0,0,0, 64'h0, 1,4'd1,64'h300, e_full(64'h300, 1, 64'h300, NOP_W, 1, 4'd1, 64'h300));
        step(1,1,0,0, 64'h0, 1,4'd1,64'h300, e_full(64'h0, 0, 64'h0, NOP_W, 0, 4'd0, 64'h0));
        step(0,0,0,0, 64'h0, 0,4'd0,64'h0, e_run(64'h4, 64'h0, 32'hC0DE0000));
        step(0,0,0,0, 64'h0, 0,4'd0,64'h0, e_run(64'h8, 64'h4, 32'hC0DE0004));
        stim_done = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        check("scoreboard_drained", 64'(sb_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
